// File: rtl/lcd_pixel_writer_if.sv
// rtl/lcd_pixel_writer_if.sv - pixel handshake between the pixel loader and the LCD writer
interface lcd_pixel_writer_if;
  logic        valid;
  logic [23:0] data;
  logic        ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lcd_pixel_writer.sv
// rtl/lcd_pixel_writer.sv - RGB888 to RGB565 frame writer for an 8080-style 8-bit LCD bus
module lcd_pixel_writer #(
  parameter int H_RES       = 480,
  parameter int V_RES       = 270,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  lcd_pixel_writer_if.slave   pix,
  output logic [7:0]          lcd_db,
  output logic                lcd_rs,
  output logic                lcd_wr_n,
  output logic                lcd_cs_n,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, LOAD, WR_LO, WR_HI, PIX_WAIT, FIN} state_t;
  // What the byte currently on the bus is, so WR_HI knows where to go next
  typedef enum logic [1:0] {K_SETUP, K_PIX_HI, K_PIX_LO} kind_t;

  localparam logic [15:0] COL_LAST = 16'(H_RES - 1);
  localparam logic [15:0] ROW_LAST = 16'(V_RES - 1);
  localparam logic [16:0] PIX_LAST = 17'(H_RES * V_RES - 1);
  localparam logic [15:0] LO_LAST  = 16'(WR_LOW_CYC - 1);
  localparam logic [15:0] HI_LAST  = 16'(WR_HIGH_CYC - 1);
  localparam logic [3:0]  SEQ_LAST = 4'd10;

  state_t      state;
  kind_t       kind;
  logic [3:0]  seq_idx;
  logic [16:0] pix_cnt;
  logic [15:0] cyc;
  logic [7:0]  pix_lo;

  // Only the top bits of each colour survive the 565 packing
  logic unused_pix_bits;
  assign unused_pix_bits = ^{pix.data[18:16], pix.data[9:8], pix.data[2:0]};

  // Window setup sequence: column range, row range, then memory write; returns {rs, byte}
  function automatic logic [8:0] setup_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return {1'b0, 8'h2A};
      4'd3:    return {1'b1, COL_LAST[15:8]};
      4'd4:    return {1'b1, COL_LAST[7:0]};
      4'd5:    return {1'b0, 8'h2B};
      4'd8:    return {1'b1, ROW_LAST[15:8]};
      4'd9:    return {1'b1, ROW_LAST[7:0]};
      4'd10:   return {1'b0, 8'h2C};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Frame sequencer: setup bytes, then per pixel a handshake and two data bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      kind      <= K_SETUP;
      seq_idx   <= '0;
      pix_cnt   <= '0;
      cyc       <= '0;
      pix_lo    <= '0;
      pix.ready <= 1'b0;
      lcd_db    <= 8'h00;
      lcd_rs    <= 1'b1;
      lcd_wr_n  <= 1'b1;
      lcd_cs_n  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state              <= LOAD;
            kind               <= K_SETUP;
            seq_idx            <= '0;
            pix_cnt            <= '0;
            busy               <= 1'b1;
            lcd_cs_n           <= 1'b0;
            {lcd_rs, lcd_db}   <= setup_byte(4'd0);
          end
        end
        // Bus already holds the byte; begin the strobe
        LOAD: begin
          state    <= WR_LO;
          lcd_wr_n <= 1'b0;
          cyc      <= '0;
        end
        WR_LO: begin
          if (cyc == LO_LAST) begin
            state    <= WR_HI;
            lcd_wr_n <= 1'b1;
            cyc      <= '0;
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        WR_HI: begin
          if (cyc != HI_LAST) begin
            cyc <= cyc + 16'd1;
          end else begin
            cyc <= '0;
            case (kind)
              K_SETUP: begin
                if (seq_idx != SEQ_LAST) begin
                  state            <= LOAD;
                  seq_idx          <= seq_idx + 4'd1;
                  {lcd_rs, lcd_db} <= setup_byte(seq_idx + 4'd1);
                end else begin
                  state     <= PIX_WAIT;
                  pix.ready <= 1'b1;
                end
              end
              K_PIX_HI: begin
                state  <= LOAD;
                kind   <= K_PIX_LO;
                lcd_db <= pix_lo;
              end
              default: begin
                if (pix_cnt == PIX_LAST) begin
                  state    <= FIN;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  lcd_cs_n <= 1'b1;
                end else begin
                  pix_cnt   <= pix_cnt + 17'd1;
                  state     <= PIX_WAIT;
                  pix.ready <= 1'b1;
                end
              end
            endcase
          end
        end
        // ready is high throughout this state, so valid alone completes the handshake
        PIX_WAIT: begin
          if (pix.valid) begin
            pix.ready <= 1'b0;
            state     <= LOAD;
            kind      <= K_PIX_HI;
            lcd_rs    <= 1'b1;
            lcd_db    <= {pix.data[23:19], pix.data[15:13]};
            pix_lo    <= {pix.data[12:10], pix.data[7:3]};
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
